// File: rtl/serial_pkg.sv
// Shared types and constants for the serial front end of the sequence-detector chain.
package serial_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_GAP   = 2'd2;

  localparam logic        IDLE_BIT_DEFAULT = 1'b0;
  localparam int unsigned WIDTH_DEFAULT    = 8;
  localparam int unsigned CNT_W            = $clog2(WIDTH_DEFAULT);
  localparam int unsigned GAP_W            = 4;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Loadable down counter; saturates at zero and flags the zero and one states.
module serial_bit_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         zero_c,
  output logic         one_c
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero_c = (cnt == '0);
  assign one_c  = (cnt == W'(1));

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: accepts words over valid/ready and emits one bit per clock on x.
module bit_serializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEFAULT,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned GAP       = 0,
  parameter logic        IDLE_BIT  = IDLE_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned BW      = cnt_w(WIDTH);
  localparam bit          HAS_GAP = (GAP != 0);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             x_nxt, x_valid_nxt, frame_done_nxt;
  logic             armed;
  logic             accept_c;
  logic             first_bit_c, next_bit_c;
  logic [WIDTH-1:0] load_shreg_c, shift_shreg_c;
  logic             bit_load, bit_en, bit_zero, bit_one;
  logic             gap_load, gap_en, gap_zero, gap_one;
  logic [BW-1:0]    bit_cnt;
  logic [GAP_W-1:0] gap_cnt;

  serial_bit_counter #(.W(BW)) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (bit_load),
    .load_val (BW'(WIDTH - 1)),
    .en       (bit_en),
    .cnt      (bit_cnt),
    .zero_c   (bit_zero),
    .one_c    (bit_one)
  );

  serial_bit_counter #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_W'(GAP)),
    .en       (gap_en),
    .cnt      (gap_cnt),
    .zero_c   (gap_zero),
    .one_c    (gap_one)
  );

  // Ready in IDLE, and on the last bit of a word when words may abut.
  assign in_ready = armed && ((state == ST_IDLE) ||
                              (!HAS_GAP && (state == ST_SHIFT) && bit_zero));
  assign accept_c = in_valid && in_ready;

  assign first_bit_c   = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
  assign next_bit_c    = MSB_FIRST ? shreg[WIDTH-1]   : shreg[0];
  assign load_shreg_c  = MSB_FIRST ? (in_data << 1)   : (in_data >> 1);
  assign shift_shreg_c = MSB_FIRST ? (shreg << 1)     : (shreg >> 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      x          <= IDLE_BIT;
      x_valid    <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      armed      <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      x          <= x_nxt;
      x_valid    <= x_valid_nxt;
      frame_done <= frame_done_nxt;
      busy       <= (state_nxt != ST_IDLE);
      armed      <= 1'b1;
    end
  end

  // Next state plus the next values of the registered outputs.
  always_comb begin
    state_nxt      = state;
    shreg_nxt      = shreg;
    x_nxt          = IDLE_BIT;
    x_valid_nxt    = 1'b0;
    frame_done_nxt = 1'b0;
    bit_load       = 1'b0;
    bit_en         = 1'b0;
    gap_load       = 1'b0;
    gap_en         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          state_nxt   = ST_SHIFT;
          shreg_nxt   = load_shreg_c;
          x_nxt       = first_bit_c;
          x_valid_nxt = 1'b1;
          bit_load    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!bit_zero) begin
          shreg_nxt      = shift_shreg_c;
          x_nxt          = next_bit_c;
          x_valid_nxt    = 1'b1;
          frame_done_nxt = bit_one;
          bit_en         = 1'b1;
        end else if (accept_c) begin
          shreg_nxt   = load_shreg_c;
          x_nxt       = first_bit_c;
          x_valid_nxt = 1'b1;
          bit_load    = 1'b1;
        end else if (HAS_GAP) begin
          state_nxt = ST_GAP;
          gap_load  = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
        gap_en = !gap_zero;
        if (gap_one || gap_zero) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench: instance 0 MSB-first/no gap, 1 LSB-first/no gap, 2 MSB-first/GAP=3.
module tb_bit_serializer;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] in_data [3];
  logic [2:0] in_valid, in_ready, x, x_valid, busy, frame_done;

  exp_t exp_q [3][$];
  int   checks = 0;
  int   errors = 0;
  int   idle_run [3];
  int   last_gap [3];
  int   vcount [3];
  int   fd_count [3];
  bit   gap_armed [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bit_serializer #(
      .WIDTH     (8),
      .MSB_FIRST (g != 1),
      .GAP       ((g == 2) ? 3 : 0),
      .IDLE_BIT  (1'b0)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data[g]),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .x          (x[g]),
      .x_valid    (x_valid[g]),
      .busy       (busy[g]),
      .frame_done (frame_done[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int g, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s [dut%0d] got %0d expected %0d at %0t", name, g, act, exp, $time);
    end
  endtask

  // Monitor: pops expected bits whenever a payload bit is presented.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (x_valid[g]) begin
        if (exp_q[g].size() == 0) begin
          check("unexpected_bit", g, 1, 0);
        end else begin
          exp_t e;
          e = exp_q[g].pop_front();
          check("x_bit", g, int'(x[g]), int'(e.b));
          check("frame_done", g, int'(frame_done[g]), int'(e.last));
        end
        if (frame_done[g]) begin
          fd_count[g]++;
          check("ready_on_last", g, int'(in_ready[g]), (g == 2) ? 0 : 1);
        end
        if (gap_armed[g]) last_gap[g] = idle_run[g];
        idle_run[g]  = 0;
        gap_armed[g] = frame_done[g];
        vcount[g]++;
      end else begin
        idle_run[g]++;
        if (frame_done[g]) check("fd_without_bit", g, 1, 0);
        if (x[g] != 1'b0) check("idle_level", g, int'(x[g]), 0);
        if (busy[g]) begin
          check("gap_idle_bit", g, int'(x[g]), 0);
          check("gap_not_ready", g, int'(in_ready[g]), 0);
        end
      end
    end
  end

  task automatic push_word(input int g, input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      int   idx;
      exp_t e;
      idx    = (g == 1) ? i : 7 - i;
      e.b    = d[idx];
      e.last = (i == 7);
      exp_q[g].push_back(e);
    end
  endtask

  // Call away from a clock edge; returns at posedge+1 after acceptance.
  task automatic send(input int g, input logic [7:0] d, input bit hold);
    int n;
    n = 0;
    in_data[g]  = d;
    in_valid[g] = 1'b1;
    while (!in_ready[g] && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      check("accept_timeout", g, 1, 0);
      in_valid[g] = 1'b0;
    end else begin
      @(posedge clk);
      push_word(g, d);
      #1;
      if (!hold) in_valid[g] = 1'b0;
    end
  endtask

  task automatic drain(input int g);
    int n;
    n = 0;
    while ((exp_q[g].size() != 0 || busy[g]) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) check("drain_timeout", g, 1, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int v0, f0;
    for (int g = 0; g < 3; g++) begin
      in_data[g]   = 8'h00;
      last_gap[g]  = -1;
      idle_run[g]  = 0;
      vcount[g]    = 0;
      fd_count[g]  = 0;
      gap_armed[g] = 1'b0;
    end
    in_valid = 3'b000;
    rst      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("rst_x", g, int'(x[g]), 0);
      check("rst_x_valid", g, int'(x_valid[g]), 0);
      check("rst_busy", g, int'(busy[g]), 0);
      check("rst_in_ready", g, int'(in_ready[g]), 0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) check("ready_after_rst", g, int'(in_ready[g]), 1);

    // MSB first, single word
    v0 = vcount[0];
    send(0, 8'b1001_0000, 1'b0);
    drain(0);
    check("word_len_msb", 0, vcount[0] - v0, 8);

    // LSB first, single word
    v0 = vcount[1];
    send(1, 8'hA5, 1'b0);
    drain(1);
    check("word_len_lsb", 1, vcount[1] - v0, 8);

    // Back-to-back, no gap
    v0 = vcount[0];
    send(0, 8'hF0, 1'b1);
    send(0, 8'h0F, 1'b0);
    drain(0);
    check("b2b_len", 0, vcount[0] - v0, 16);
    check("b2b_bubble", 0, last_gap[0], 0);

    // GAP=3: three gap cycles plus the IDLE accept cycle separate the words
    v0 = vcount[2];
    send(2, 8'hF0, 1'b1);
    send(2, 8'h0F, 1'b0);
    drain(2);
    check("gap_len", 2, vcount[2] - v0, 16);
    check("gap_cycles", 2, last_gap[2], 4);

    // Reset after four bits of 8'hFF
    f0 = fd_count[0];
    send(0, 8'hFF, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    exp_q[0].delete();
    #1;
    check("midrst_x_valid", 0, int'(x_valid[0]), 0);
    check("midrst_busy", 0, int'(busy[0]), 0);
    check("midrst_x", 0, int'(x[0]), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_no_fd", 0, fd_count[0] - f0, 0);
    v0 = vcount[0];
    send(0, 8'hFF, 1'b0);
    drain(0);
    check("post_rst_len", 0, vcount[0] - v0, 8);
    check("post_rst_fd", 0, fd_count[0] - f0, 1);

    repeat (3) @(posedge clk);
    for (int g = 0; g < 3; g++) check("queue_empty", g, exp_q[g].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
